// File: rtl/decode_pkg.sv
// Shared decode definitions for decode_execute: opcodes, functs, FSM states,
// instruction field positions and the instruction classifier.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int IMM_MSB = 15;

    typedef enum logic [2:0] {
        S_IDLE, S_DEC, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD, ALU_SLL, ALU_SRL, ALU_SLLV
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    legal;
        logic    rtype;
        logic    is_lw;
        logic    is_j;
        logic    wr_en;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.alu_op = ALU_ADD;
        d.legal  = 1'b0;
        d.rtype  = 1'b0;
        d.is_lw  = 1'b0;
        d.is_j   = 1'b0;
        d.wr_en  = 1'b0;
        case (ins[OP_MSB:OP_LSB])
            OP_RTYPE: begin
                d.rtype = 1'b1;
                d.legal = 1'b1;
                d.wr_en = 1'b1;
                case (ins[FN_MSB:0])
                    FN_ADD:  d.alu_op = ALU_ADD;
                    FN_SLL:  d.alu_op = ALU_SLL;
                    FN_SRL:  d.alu_op = ALU_SRL;
                    FN_SLLV: d.alu_op = ALU_SLLV;
                    default: begin
                        d.legal = 1'b0;
                        d.wr_en = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                d.legal = 1'b1;
                d.wr_en = 1'b1;
            end
            OP_LW: begin
                d.legal = 1'b1;
                d.wr_en = 1'b1;
                d.is_lw = 1'b1;
            end
            OP_J: begin
                d.legal = 1'b1;
                d.is_j  = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_execute_if.sv
// Instruction-fetch, data-memory and debug signals of decode_execute.
// master = the decode/execute stage, slave = its environment.
interface decode_execute_if #(parameter int PC_W = 4);
    logic [31:0]     instr;
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            retire;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic [4:0]      dbg_addr;
    logic [31:0]     dbg_data;
    logic            illegal;

    modport master (
        input  instr, instr_valid, mem_ack, mem_rdata, dbg_addr,
        output pc, busy, retire, mem_req, mem_addr, dbg_data, illegal
    );

    modport slave (
        output instr, instr_valid, mem_ack, mem_rdata, dbg_addr,
        input  pc, busy, retire, mem_req, mem_addr, dbg_data, illegal
    );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the supported subset: add and the three shift forms.
module exec_alu
    import decode_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);
    always_comb begin
        y = a + b;
        case (op)
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SLLV: y = b << a[4:0];
            default:  y = a + b;
        endcase
    end
endmodule

// File: rtl/decode_execute.sv
// Multi-cycle decode/execute/writeback stage: FSM, PC and 32x32 register file.
// Define ILLEGAL_TRAP_EN to halt on unsupported encodings instead of NOP-ing them.
module decode_execute
    import decode_pkg::*;
#(
    parameter int PC_W = 4,
    parameter int NREG = 32
) (
    input  logic               clk,
    input  logic               rst,
    decode_execute_if.master   bus
);
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t          state;
    logic [31:0]     instr_q, a_q, b_q, result_q, mem_addr_q;
    logic [PC_W-1:0] pc_q;
    logic            busy_q, retire_q, mem_req_q, illegal_q, wr_en_q, is_j_q;
    logic [4:0]      wr_idx_q;
    logic [31:0]     regs [NREG];
    dec_t            dec;
    logic [31:0]     alu_y;

    assign dec = decode(instr_q);

    exec_alu u_alu (
        .op    (dec.alu_op),
        .a     (a_q),
        .b     (b_q),
        .shamt (instr_q[SH_MSB:SH_LSB]),
        .y     (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc_q       <= '0;
            busy_q     <= 1'b0;
            retire_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            illegal_q  <= 1'b0;
            instr_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            wr_en_q    <= 1'b0;
            is_j_q     <= 1'b0;
            wr_idx_q   <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        busy_q  <= 1'b1;
                        state   <= S_DEC;
                    end
                end
                S_DEC: begin
                    a_q   <= regs[instr_q[RS_MSB:RS_LSB]];
                    b_q   <= dec.rtype ? regs[instr_q[RT_MSB:RT_LSB]]
                                       : {{16{instr_q[IMM_MSB]}}, instr_q[IMM_MSB:0]};
                    state <= S_EX;
                end
                S_EX: begin
                    result_q <= alu_y;
                    wr_en_q  <= dec.wr_en & dec.legal;
                    wr_idx_q <= dec.rtype ? instr_q[RD_MSB:RD_LSB] : instr_q[RT_MSB:RT_LSB];
                    is_j_q   <= dec.is_j;
                    if (TRAP_EN && !dec.legal) begin
                        illegal_q <= 1'b1;
                        state     <= S_HALT;
                    end else if (dec.is_lw) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= alu_y;
                        state      <= S_MEM;
                    end else begin
                        retire_q <= 1'b1;
                        state    <= S_WB;
                    end
                end
                // Load data replaces the address in result_q on the acknowledging edge
                S_MEM: begin
                    if (bus.mem_ack) begin
                        result_q  <= bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        retire_q  <= 1'b1;
                        state     <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_en_q && wr_idx_q != '0) regs[wr_idx_q] <= result_q;
                    pc_q   <= is_j_q ? instr_q[PC_W-1:0] : pc_q + 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.busy     = busy_q;
    assign bus.retire   = retire_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.illegal  = illegal_q;
    assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs[bus.dbg_addr];

endmodule

// File: tb/tb_decode_execute.sv
// Directed bench for decode_execute: hand-computed vectors for ALU ops, lw handshake,
// jumps, PC wrap, illegal encodings (either build) and asynchronous reset.
module tb_decode_execute;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    decode_execute_if #(.PC_W(4)) bus();

    decode_execute #(.PC_W(4), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        bus.dbg_addr = idx;
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    task automatic chk_pc(input logic [3:0] exp, input string tag);
        check(tag, {28'd0, bus.pc}, {28'd0, exp});
    endtask

    // Issues one non-load instruction and checks the retire pulse lands in the third cycle.
    task automatic run_instr(input logic [31:0] ins, input string tag);
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check({tag, "_early"}, {31'd0, bus.retire}, 32'd0);
        @(negedge clk);
        check({tag, "_retire"}, {31'd0, bus.retire}, 32'd1);
        @(negedge clk);
        check({tag, "_done"}, {30'd0, bus.retire, bus.busy}, 32'd0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.dbg_addr    = '0;
        #1;
        chk_pc(4'd0, "rst_pc");
        check("rst_ctl", {28'd0, bus.busy, bus.retire, bus.mem_req, bus.illegal}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        chk_reg(5'd4, 32'd0, "rst_r4");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // addi $4,$0,0x3456
        run_instr(32'h20043456, "addi4");
        chk_reg(5'd4, 32'h00003456, "r4");
        chk_pc(4'd1, "pc1");

        // addi $5,$0,-1 ; sll $6,$4,1
        run_instr(32'h2005FFFF, "addi5");
        chk_reg(5'd5, 32'hFFFFFFFF, "r5");
        run_instr(32'h00043040, "sll");
        chk_reg(5'd6, 32'h000068AC, "r6");
        chk_pc(4'd3, "pc3");

        // add $7,$4,$5 ; srl $8,$5,4 ; sllv $9,$5,$4
        run_instr(32'h00853820, "add");
        chk_reg(5'd7, 32'h00003455, "r7");
        run_instr(32'h00054102, "srl");
        chk_reg(5'd8, 32'h0FFFFFFF, "r8");
        run_instr(32'h00854804, "sllv");
        chk_reg(5'd9, 32'hFFC00000, "r9");
        chk_pc(4'd6, "pc6");

        // lw $5,0x9ABC($4), acknowledged in the third MEM cycle
        @(negedge clk);
        bus.instr       = 32'h8C859ABC;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("lw_noreq_ex", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        check("lw_req1", {31'd0, bus.mem_req}, 32'd1);
        check("lw_addr", bus.mem_addr, 32'hFFFFCF12);
        check("lw_noret", {31'd0, bus.retire}, 32'd0);
        @(negedge clk);
        check("lw_req2", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        check("lw_req3", {31'd0, bus.mem_req}, 32'd1);
        check("lw_addr3", bus.mem_addr, 32'hFFFFCF12);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        check("lw_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check("lw_retire", {31'd0, bus.retire}, 32'd1);
        @(negedge clk);
        chk_reg(5'd5, 32'hDEADBEEF, "lw_r5");
        chk_pc(4'd7, "pc7");

        // j 0x0123456 -> pc 6, no register touched
        run_instr(32'h08123456, "j6");
        chk_pc(4'd6, "j_pc6");
        chk_reg(5'd5, 32'hDEADBEEF, "j_r5");
        chk_reg(5'd4, 32'h00003456, "j_r4");

        // j 15, then addi $0 wraps pc to 0 and leaves $0 at zero
        run_instr(32'h0800000F, "j15");
        chk_pc(4'd15, "pc15");
        run_instr(32'h20000005, "addi0");
        chk_pc(4'd0, "pc_wrap");
        chk_reg(5'd0, 32'd0, "r0");

`ifdef ILLEGAL_TRAP_EN
        @(negedge clk);
        bus.instr       = 32'hFC000000;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("trap_illegal", {31'd0, bus.illegal}, 32'd1);
        check("trap_busy", {31'd0, bus.busy}, 32'd1);
        check("trap_noret", {31'd0, bus.retire}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("halt_busy", {31'd0, bus.busy}, 32'd1);
        chk_pc(4'd0, "halt_pc");
        rst = 1'b1;
        #1;
        check("halt_rst", {30'd0, bus.busy, bus.illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        run_instr(32'hFC000000, "nop");
        chk_pc(4'd1, "nop_pc");
        check("nop_illegal", {31'd0, bus.illegal}, 32'd0);
        chk_reg(5'd4, 32'h00003456, "nop_r4");
        rst = 1'b1;
        #1;
        rst = 1'b0;
`endif

        // addi $4 with instr_valid held high in DEC and EX must not start a second instruction
        @(negedge clk);
        bus.instr       = 32'h20043456;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr       = 32'h20070009;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("ign_retire", {31'd0, bus.retire}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("ign_idle", {31'd0, bus.busy}, 32'd0);
        chk_reg(5'd7, 32'd0, "ign_r7");
        chk_reg(5'd4, 32'h00003456, "ign_r4");
        chk_pc(4'd1, "ign_pc");

        // lw again, then asynchronous reset in the middle of MEM
        @(negedge clk);
        bus.instr       = 32'h8C859ABC;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_req", {31'd0, bus.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk_pc(4'd0, "mid_pc");
        chk_reg(5'd4, 32'd0, "mid_r4");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reg(5'd5, 32'd0, "mid_r5");
        check("mid_quiet", {30'd0, bus.mem_req, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
